// File: rtl/pong_pkg.sv
// Shared encodings for the Pong game-flow controller: FSM states, pause-menu codes,
// winner codes and the state-to-enable decode used by the top level.
package pong_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_START = 3'd0;
  localparam logic [STATE_W-1:0] ST_SERVE = 3'd1;
  localparam logic [STATE_W-1:0] ST_PLAY  = 3'd2;
  localparam logic [STATE_W-1:0] ST_PAUSE = 3'd3;
  localparam logic [STATE_W-1:0] ST_OVER  = 3'd4;

  localparam int MENU_RESUME  = 0;
  localparam int MENU_RESTART = 1;
  localparam int MENU_QUIT    = 2;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  typedef struct packed {
    logic start;
    logic serve;
    logic game;
    logic pause;
    logic over;
  } enables_t;

  // One-hot block enables for a given state; unknown encodings enable nothing.
  function automatic enables_t state_enables(input logic [STATE_W-1:0] st);
    enables_t en;
    en = '0;
    case (st)
      ST_START: en.start = 1'b1;
      ST_SERVE: en.serve = 1'b1;
      ST_PLAY:  en.game  = 1'b1;
      ST_PAUSE: en.pause = 1'b1;
      ST_OVER:  en.over  = 1'b1;
      default:  en = '0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/pong_edge_detect.sv
// Rising-edge detector for the joystick button: one pulse per press, held levels ignored.
module pong_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic enter,
  output logic rise
);

  logic enter_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enter_q <= 1'b0;
    end else begin
      enter_q <= enter;
    end
  end

  // Combinational so the FSM acts on the same edge that sees the rise.
  assign rise = enter & ~enter_q;

endmodule

// File: rtl/pong_flow_fsm.sv
// Top-level Pong game-flow controller: START/SERVE/PLAY/PAUSE/GAME_OVER sequencing,
// score keeping, winner declaration, block enables and a one-cycle game reset.
module pong_flow_fsm
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 60,
  parameter int MENU_ITEMS  = 3,
  parameter int VAL_W       = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enter,
  input  logic [VAL_W-1:0]                 value,
  input  logic                             frame_tick,
  input  logic                             point_p1,
  input  logic                             point_p2,
  output logic                             enable_start,
  output logic                             enable_serve,
  output logic                             enable_game,
  output logic                             enable_pause,
  output logic                             enable_over,
  output logic                             game_rst,
  output logic [$clog2(WIN_SCORE+1)-1:0]   score_p1,
  output logic [$clog2(WIN_SCORE+1)-1:0]   score_p2,
  output logic [1:0]                       winner,
  output logic [$clog2(SERVE_TICKS+1)-1:0] serve_count,
  output logic [STATE_W-1:0]               state_dbg
);

  localparam int SCORE_W = $clog2(WIN_SCORE + 1);
  localparam int CNT_W   = $clog2(SERVE_TICKS + 1);

  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W:0]   WIN_EXT    = (SCORE_W + 1)'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_TICKS);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  logic [STATE_W-1:0] state, state_n;
  logic               press;
  enables_t           en_n;

  // Next-state side effects, decoded once and consumed by the register blocks.
  logic rst_pulse;
  logic clear_scores;
  logic take_points;
  logic load_serve;
  logic dec_serve;
  logic zero_serve;

  logic [SCORE_W:0]   sum_p1, sum_p2;
  logic [SCORE_W-1:0] new_p1, new_p2;
  logic               p1_hit, p2_hit, any_point;
  logic [31:0]        menu_code;
  logic               menu_ok;
  logic [1:0]         winner_n;

  pong_edge_detect u_edge (
    .clock (clock),
    .reset (reset),
    .enter (enter),
    .rise  (press)
  );

  // Saturating score candidates for this cycle's points.
  always_comb begin
    sum_p1 = {1'b0, score_p1} + {{SCORE_W{1'b0}}, point_p1};
    sum_p2 = {1'b0, score_p2} + {{SCORE_W{1'b0}}, point_p2};
    new_p1 = (sum_p1 >= WIN_EXT) ? WIN_S : sum_p1[SCORE_W-1:0];
    new_p2 = (sum_p2 >= WIN_EXT) ? WIN_S : sum_p2[SCORE_W-1:0];
    p1_hit = (new_p1 == WIN_S);
    p2_hit = (new_p2 == WIN_S);
    any_point = point_p1 | point_p2;
    if (p1_hit && p2_hit) begin
      winner_n = WIN_TIE;
    end else if (p1_hit) begin
      winner_n = WIN_P1;
    end else if (p2_hit) begin
      winner_n = WIN_P2;
    end else begin
      winner_n = WIN_NONE;
    end
  end

  assign menu_code = 32'(value);
  assign menu_ok   = (menu_code < MENU_ITEMS);

  always_comb begin
    state_n      = state;
    rst_pulse    = 1'b0;
    clear_scores = 1'b0;
    take_points  = 1'b0;
    load_serve   = 1'b0;
    dec_serve    = 1'b0;
    zero_serve   = 1'b0;
    case (state)
      ST_START: begin
        if (press) begin
          state_n      = ST_SERVE;
          rst_pulse    = 1'b1;
          clear_scores = 1'b1;
          load_serve   = 1'b1;
        end
      end
      ST_SERVE: begin
        // A press freezes the countdown even if a frame tick lands on the same edge.
        if (press) begin
          state_n = ST_PAUSE;
        end else if (frame_tick) begin
          if (serve_count <= CNT_ONE) begin
            state_n    = ST_PLAY;
            zero_serve = 1'b1;
          end else begin
            dec_serve = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (any_point) begin
          take_points = 1'b1;
          if (p1_hit || p2_hit) begin
            state_n = ST_OVER;
          end else begin
            state_n    = ST_SERVE;
            load_serve = 1'b1;
          end
        end else if (press) begin
          state_n = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (press && menu_ok) begin
          if (menu_code == MENU_RESUME) begin
            state_n    = ST_SERVE;
            load_serve = 1'b1;
          end else if (menu_code == MENU_RESTART) begin
            state_n      = ST_SERVE;
            rst_pulse    = 1'b1;
            clear_scores = 1'b1;
            load_serve   = 1'b1;
          end else if (menu_code == MENU_QUIT) begin
            state_n      = ST_START;
            clear_scores = 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (press) begin
          state_n = ST_START;
        end
      end
      default: begin
        state_n      = ST_START;
        rst_pulse    = 1'b1;
        clear_scores = 1'b1;
        zero_serve   = 1'b1;
      end
    endcase
  end

  assign en_n = state_enables(state_n);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_START;
      game_rst     <= 1'b0;
      enable_start <= 1'b1;
      enable_serve <= 1'b0;
      enable_game  <= 1'b0;
      enable_pause <= 1'b0;
      enable_over  <= 1'b0;
    end else begin
      state        <= state_n;
      game_rst     <= ~rst_pulse;
      enable_start <= en_n.start;
      enable_serve <= en_n.serve;
      enable_game  <= en_n.game;
      enable_pause <= en_n.pause;
      enable_over  <= en_n.over;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      score_p1 <= '0;
      score_p2 <= '0;
      winner   <= WIN_NONE;
    end else if (clear_scores) begin
      score_p1 <= '0;
      score_p2 <= '0;
      winner   <= WIN_NONE;
    end else if (take_points) begin
      score_p1 <= new_p1;
      score_p2 <= new_p2;
      winner   <= winner_n;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      serve_count <= '0;
    end else if (load_serve) begin
      serve_count <= SERVE_LOAD;
    end else if (zero_serve) begin
      serve_count <= '0;
    end else if (dec_serve) begin
      serve_count <= serve_count - CNT_ONE;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pong_flow_fsm.sv
// Bench for pong_flow_fsm: directed game scenarios plus random play, checked every cycle
// against a behavioural game model through an expected-value queue.
module tb_pong_flow_fsm;

  localparam int WIN   = 2;
  localparam int TICKS = 3;

  typedef enum int {M_START, M_SERVE, M_PLAY, M_PAUSE, M_OVER} mode_t;

  localparam logic [13:0] RST_VEC = {5'b10000, 1'b0, 8'b0};

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enter = 1'b0;
  logic [1:0] value = 2'd0;
  logic       frame_tick = 1'b0;
  logic       point_p1 = 1'b0;
  logic       point_p2 = 1'b0;

  logic       enable_start, enable_serve, enable_game, enable_pause, enable_over;
  logic       game_rst;
  logic [1:0] score_p1, score_p2, winner, serve_count;
  logic [2:0] state_dbg;
  logic [13:0] dut_vec;

  logic [13:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  mode_t m_mode;
  int    m_s1, m_s2, m_win, m_cnt;
  logic  m_rst, m_prev;

  pong_flow_fsm #(
    .WIN_SCORE   (WIN),
    .SERVE_TICKS (TICKS),
    .MENU_ITEMS  (3),
    .VAL_W       (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enter        (enter),
    .value        (value),
    .frame_tick   (frame_tick),
    .point_p1     (point_p1),
    .point_p2     (point_p2),
    .enable_start (enable_start),
    .enable_serve (enable_serve),
    .enable_game  (enable_game),
    .enable_pause (enable_pause),
    .enable_over  (enable_over),
    .game_rst     (game_rst),
    .score_p1     (score_p1),
    .score_p2     (score_p2),
    .winner       (winner),
    .serve_count  (serve_count),
    .state_dbg    (state_dbg)
  );

  assign dut_vec = {enable_start, enable_serve, enable_game, enable_pause, enable_over,
                    game_rst, score_p1, score_p2, winner, serve_count};

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1);
  end

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference model of the game rules
  task automatic model_reset();
    m_mode = M_START;
    m_s1 = 0; m_s2 = 0; m_win = 0; m_cnt = 0;
    m_rst = 1'b0; m_prev = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic [1:0] val, input logic tk,
                            input logic p1, input logic p2);
    logic pr;
    pr = en && !m_prev;
    m_prev = en;
    m_rst = 1'b1;
    case (m_mode)
      M_START: if (pr) begin
        m_mode = M_SERVE; m_rst = 1'b0;
        m_s1 = 0; m_s2 = 0; m_win = 0; m_cnt = TICKS;
      end
      M_SERVE: begin
        if (pr) m_mode = M_PAUSE;
        else if (tk) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) m_mode = M_PLAY;
        end
      end
      M_PLAY: begin
        if (p1 || p2) begin
          m_s1 = (m_s1 + int'(p1) > WIN) ? WIN : m_s1 + int'(p1);
          m_s2 = (m_s2 + int'(p2) > WIN) ? WIN : m_s2 + int'(p2);
          if (m_s1 >= WIN || m_s2 >= WIN) begin
            m_mode = M_OVER;
            m_win = (m_s1 >= WIN ? 1 : 0) + (m_s2 >= WIN ? 2 : 0);
          end else begin
            m_mode = M_SERVE; m_cnt = TICKS;
          end
        end else if (pr) m_mode = M_PAUSE;
      end
      M_PAUSE: if (pr) begin
        if (val == 2'd0) begin
          m_mode = M_SERVE; m_cnt = TICKS;
        end else if (val == 2'd1) begin
          m_mode = M_SERVE; m_rst = 1'b0; m_cnt = TICKS;
          m_s1 = 0; m_s2 = 0; m_win = 0;
        end else if (val == 2'd2) begin
          m_mode = M_START; m_s1 = 0; m_s2 = 0; m_win = 0;
        end
      end
      M_OVER: if (pr) m_mode = M_START;
      default: m_mode = M_START;
    endcase
  endtask

  function automatic logic [13:0] model_vec();
    logic [4:0] en;
    case (m_mode)
      M_START: en = 5'b10000;
      M_SERVE: en = 5'b01000;
      M_PLAY:  en = 5'b00100;
      M_PAUSE: en = 5'b00010;
      default: en = 5'b00001;
    endcase
    return {en, m_rst, 2'(m_s1), 2'(m_s2), 2'(m_win), 2'(m_cnt)};
  endfunction

  // Driver tasks: inputs change on the falling edge; each call spans one rising edge
  task automatic step(input logic en, input logic [1:0] val, input logic tk,
                      input logic p1, input logic p2);
    @(negedge clock);
    enter = en; value = val; frame_tick = tk; point_p1 = p1; point_p2 = p2;
    model_step(en, val, tk, p1, p2);
    exp_q.push_back(model_vec());
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1;
    reset = 1'b0;
    enter = 1'b0; frame_tick = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0;
    #1;
    check("reset_async", dut_vec, RST_VEC);
    model_reset();
    @(posedge clock);
    #2;
    check("reset_hold", dut_vec, RST_VEC);
    reset = 1'b1;
  endtask

  // Scoreboard monitor: one expected output vector per rising edge
  always @(posedge clock) begin : monitor
    logic [13:0] e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("cycle", dut_vec, e);
    end
  end

  initial begin
    model_reset();
    do_reset();

    idle();
    check("rst_release", {13'b0, game_rst}, 14'd1);
    check("start_en", {13'b0, enable_start}, 14'd1);

    // START -> SERVE, countdown to PLAY
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    check("start_press_rst", {13'b0, game_rst}, 14'd0);
    check("serve_load", {12'b0, serve_count}, 14'd3);
    idle();
    ticks(3);
    check("serve_to_play", {13'b0, enable_game}, 14'd1);
    check("serve_cnt_zero", {12'b0, serve_count}, 14'd0);

    // Player 1 wins 2-0
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    ticks(3);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    check("p1_over", {13'b0, enable_over}, 14'd1);
    check("p1_winner", {12'b0, winner}, 14'd1);
    check("p1_score", {12'b0, score_p1}, 14'd2);
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    check("over_to_start", {13'b0, enable_start}, 14'd1);
    check("score_held", {12'b0, score_p1}, 14'd2);
    idle();

    // 1-1 then simultaneous points: tie
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    idle();
    ticks(3);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    ticks(3);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    ticks(3);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    check("tie_winner", {12'b0, winner}, 14'd3);
    check("tie_over", {13'b0, enable_over}, 14'd1);
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    idle();

    // Held enter pauses once; bad menu code stays; restart clears
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    idle();
    ticks(3);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    ticks(3);
    repeat (10) step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    check("hold_pause", {13'b0, enable_pause}, 14'd1);
    step(1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    check("bad_menu_stays", {13'b0, enable_pause}, 14'd1);
    step(1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    check("restart_serve", {13'b0, enable_serve}, 14'd1);
    check("restart_rst", {13'b0, game_rst}, 14'd0);
    check("restart_clear", {12'b0, score_p1}, 14'd0);
    idle();

    // Point beats press; then reset in the middle of SERVE
    ticks(3);
    step(1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    check("point_beats_press", {13'b0, enable_serve}, 14'd1);
    check("point_scored", {12'b0, score_p1}, 14'd1);
    idle();
    ticks(1);
    do_reset();

    // Random play against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 7) == 0));
      end
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
